answer_checker: RTL

- Stage directly downstream of the safe's answer-calculation block.
- Latches that block's 16-bit correct answer at round start, then accumulates the user's decimal keypad entry.
- On Enter, compares the entry against the latched answer and drives unlock, fail and lockout status.
- Enforces a retry limit with a timed lockout; feeds the door/LED/FND output logic.

---
 rtl/safe_pkg.sv | 23 ++
 rtl/bcd_accum.sv | 42 ++++
 rtl/answer_checker.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/safe_pkg.sv
// Shared definitions for the safe's answer-checking stage: key codes,
// checker FSM states and the answer width.
package safe_pkg;

  localparam int ANS_W = 16;

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_RELOCK = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_accum.sv
// Decimal keypad accumulator: value = value*10 + digit, bounded to MAX_DIGITS
// digits; clear has priority over a digit in the same cycle.
module bcd_accum
  import safe_pkg::*;
#(
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_dig_en,
  input  logic [3:0]       i_digit,
  output logic [ANS_W-1:0] o_val,
  output logic [2:0]       o_cnt
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  logic [ANS_W-1:0] r_val;
  logic [2:0]       r_cnt;

  // Accumulate accepted digits; digits beyond the limit are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= '0;
      r_cnt <= 3'd0;
    end else if (i_clr) begin
      r_val <= '0;
      r_cnt <= 3'd0;
    end else if (i_dig_en && (r_cnt < MAX_CNT)) begin
      r_val <= r_val * 16'd10 + {12'd0, i_digit};
      r_cnt <= r_cnt + 3'd1;
    end else begin
      r_val <= r_val;
      r_cnt <= r_cnt;
    end
  end

  assign o_val = r_val;
  assign o_cnt = r_cnt;

endmodule

// File: rtl/answer_checker.sv
// Safe answer checker: latches the answer, takes keypad entry, grants unlock or
// counts failures into a timed lockout. Optional idle timeout: ENTRY_TIMEOUT_EN.
module answer_checker
  import safe_pkg::*;
#(
  parameter int MAX_DIGITS  = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1000
`ifdef ENTRY_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 500
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ANS_W-1:0] correct_ans,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [ANS_W-1:0] entry_val,
  output logic [2:0]       digit_cnt,
  output logic [1:0]       tries_left,
  output logic             unlock,
  output logic             fail_pulse,
  output logic             locked
);

  localparam int              LOCK_W     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [1:0]      TRIES_INIT = 2'(MAX_TRIES);

  state_e             r_state;
  logic [ANS_W-1:0]   r_ans;
  logic [LOCK_W-1:0]  r_lock_tmr;
  logic [1:0]         r_tries;
  logic               r_unlock;
  logic               r_fail;
  logic               r_locked;

  logic               w_acc_clr;
  logic               w_acc_dig;
  logic               w_match;
  logic               w_timeout;

  assign w_match = (entry_val == r_ans);

  bcd_accum #(
    .MAX_DIGITS(MAX_DIGITS)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_acc_clr),
    .i_dig_en (w_acc_dig),
    .i_digit  (key_code),
    .o_val    (entry_val),
    .o_cnt    (digit_cnt)
  );

`ifdef ENTRY_TIMEOUT_EN
  localparam int            TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;

  // Idle timer for a partial entry; any key restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if ((r_state != ST_ENTRY) || key_valid || (digit_cnt == 3'd0)) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt == TO_LAST) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_ENTRY) && !key_valid &&
                     (digit_cnt != 3'd0) && (r_to_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // Accumulator commands decoded from the current state and key strobe.
  always_comb begin
    w_acc_clr = 1'b0;
    w_acc_dig = 1'b0;
    case (r_state)
      ST_IDLE, ST_OPEN: begin
        w_acc_clr = start;
      end
      ST_ENTRY: begin
        if (key_valid && (key_code == KEY_CLEAR)) begin
          w_acc_clr = 1'b1;
        end else if (key_valid && is_digit(key_code)) begin
          w_acc_dig = 1'b1;
        end else begin
          w_acc_clr = w_timeout;
        end
      end
      ST_CHECK: begin
        w_acc_clr = !w_match;
      end
      ST_LOCKOUT: begin
        w_acc_clr = (r_lock_tmr == '0);
      end
      default: begin
        w_acc_clr = 1'b1;
      end
    endcase
  end

  // Round control, try counter and lockout timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ans      <= '0;
      r_lock_tmr <= '0;
      r_tries    <= 2'd0;
      r_unlock   <= 1'b0;
      r_fail     <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_fail <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ans   <= correct_ans;
            r_tries <= TRIES_INIT;
            r_state <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (key_valid && (key_code == KEY_ENTER) && (digit_cnt != 3'd0)) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_match) begin
            r_unlock <= 1'b1;
            r_state  <= ST_OPEN;
          end else if (r_tries > 2'd1) begin
            r_tries <= r_tries - 2'd1;
            r_fail  <= 1'b1;
            r_state <= ST_ENTRY;
          end else begin
            r_tries    <= 2'd0;
            r_lock_tmr <= LOCK_LOAD;
            r_locked   <= 1'b1;
            r_state    <= ST_LOCKOUT;
          end
        end
        ST_OPEN: begin
          if (start) begin
            r_ans    <= correct_ans;
            r_tries  <= TRIES_INIT;
            r_unlock <= 1'b0;
            r_state  <= ST_ENTRY;
          end else if (key_valid && (key_code == KEY_RELOCK)) begin
            r_unlock <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_LOCKOUT: begin
          if (r_lock_tmr == '0) begin
            r_locked <= 1'b0;
            r_tries  <= TRIES_INIT;
            r_state  <= ST_ENTRY;
          end else begin
            r_lock_tmr <= r_lock_tmr - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tries_left = r_tries;
  assign unlock     = r_unlock;
  assign fail_pulse = r_fail;
  assign locked     = r_locked;

endmodule
